// File: rtl/oq_regs_pkg.sv
// oq_regs_pkg: shared widths and helpers for the output-queue status registers
package oq_regs_pkg;
    localparam int PEND_DEPTH_DEF = 4;
    // ceil(log2(n)), never less than 1 so single-entry widths stay legal
    function automatic int log2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction
    // deferred-update FIFO entry: {queue index, packet count}
    function automatic int entry_width(input int oq_w, input int pkts_w);
        return oq_w + pkts_w;
    endfunction
endpackage

// File: rtl/oq_regs_pend_fifo.sv
// oq_regs_pend_fifo: deferred store-update FIFO with per-entry cancel by key
//   push_i/din_i      enqueue an entry (caller guarantees !full_o or pop_i)
//   pop_i             drop the head entry (live or cancelled)
//   kill_i/kill_key_i cancel every queued entry whose key (top KEY_W bits) matches
//   head_o            head entry; head_occ_o slot occupied; head_live_o not cancelled
//   full_o            all slots occupied; count_o number of live entries
module oq_regs_pend_fifo
    import oq_regs_pkg::*;
#(
    parameter int DEPTH = PEND_DEPTH_DEF,
    parameter int WIDTH = 14,
    parameter int KEY_W = 3,
    parameter int CNT_W = log2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             kill_i,
    input  logic [KEY_W-1:0] kill_key_i,
    output logic [WIDTH-1:0] head_o,
    output logic             head_occ_o,
    output logic             head_live_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int AW = log2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0]    rptr_q, wptr_q;
    logic [CNT_W-1:0] occ_q;

    assign head_o      = mem_q[rptr_q];
    assign head_occ_o  = occ_q != '0;
    assign head_live_o = live_q[rptr_q];
    assign full_o      = occ_q == CNT_W'(DEPTH);

    // cancelled entries keep their slot until they reach the head and are popped
    always_comb begin
        live_d = live_q;
        for (int i = 0; i < DEPTH; i++)
            if (kill_i && mem_q[i][WIDTH-1 -: KEY_W] == kill_key_i) live_d[i] = 1'b0;
        if (pop_i) live_d[rptr_q] = 1'b0;
        if (push_i) live_d[wptr_q] = 1'b1;
    end

    always_comb begin
        count_o = '0;
        for (int i = 0; i < DEPTH; i++) count_o = count_o + CNT_W'(live_q[i]);
    end

    always_ff @(posedge clk)
        if (push_i) mem_q[wptr_q] <= din_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            live_q <= '0;
            rptr_q <= '0;
            wptr_q <= '0;
            occ_q  <= '0;
        end else begin
            live_q <= live_d;
            rptr_q <= pop_i ? rptr_q + AW'(1) : rptr_q;
            wptr_q <= push_i ? wptr_q + AW'(1) : wptr_q;
            occ_q  <= occ_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end
endmodule

// File: rtl/oq_regs_eval_status.sv
// oq_regs_eval_status: per-queue empty/full flags from store/remove packet counts
//   dst_*_i      store side: update latches queue index, done applies the count
//   src_*_i      remove side: same handshake, highest write priority
//   initialize_i force a queue to empty (deferred, lowest priority)
//   thresh_*_i   per-queue full threshold (0 = never full)
//   empty_o/full_o per-queue flags; pend_count_o live deferred entries;
//   pend_overflow_o sticky, a store update was dropped
module oq_regs_eval_status
    import oq_regs_pkg::*;
#(
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int NUM_OQ_WIDTH      = log2(NUM_OUTPUT_QUEUES),
    parameter int PKTS_IN_RAM_WIDTH = 11,
    parameter int PEND_DEPTH        = PEND_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dst_update_i,
    input  logic [NUM_OQ_WIDTH-1:0]      dst_oq_i,
    input  logic [PKTS_IN_RAM_WIDTH-1:0] dst_num_pkts_in_q_i,
    input  logic                         dst_num_pkts_in_q_done_i,
    input  logic                         src_update_i,
    input  logic [NUM_OQ_WIDTH-1:0]      src_oq_i,
    input  logic [PKTS_IN_RAM_WIDTH-1:0] src_num_pkts_in_q_i,
    input  logic                         src_num_pkts_in_q_done_i,
    input  logic                         initialize_i,
    input  logic [NUM_OQ_WIDTH-1:0]      initialize_oq_i,
    input  logic                         thresh_wr_i,
    input  logic [NUM_OQ_WIDTH-1:0]      thresh_oq_i,
    input  logic [PKTS_IN_RAM_WIDTH-1:0] thresh_val_i,
    output logic [NUM_OUTPUT_QUEUES-1:0] empty_o,
    output logic [NUM_OUTPUT_QUEUES-1:0] full_o,
    output logic [log2(PEND_DEPTH):0]    pend_count_o,
    output logic                         pend_overflow_o
);
    localparam int EW   = entry_width(NUM_OQ_WIDTH, PKTS_IN_RAM_WIDTH);
    localparam int PC_W = log2(PEND_DEPTH) + 1;
    logic [NUM_OQ_WIDTH-1:0]      dst_oq_q, src_oq_q, dst_oq, src_oq, wr_oq, init_oq;
    logic [PKTS_IN_RAM_WIDTH-1:0] thresh_q [NUM_OUTPUT_QUEUES];
    logic [PKTS_IN_RAM_WIDTH-1:0] wr_cnt;
    logic [NUM_OUTPUT_QUEUES-1:0] empty_q, empty_d, full_q, full_d, init_pend_q, init_pend_d;
    logic                         pend_overflow_q;
    logic [EW-1:0]                head;
    logic [PC_W-1:0]              pend_cnt;
    logic head_occ, head_live, fifo_full;
    logic src_done, dst_done, fifo_wr, direct_wr, init_wr, need_enq, push, pop;

    assign src_done = src_num_pkts_in_q_done_i;
    assign dst_done = dst_num_pkts_in_q_done_i;
    // an update in the same cycle as done steers done to the new index
    assign dst_oq   = dst_update_i ? dst_oq_i : dst_oq_q;
    assign src_oq   = src_update_i ? src_oq_i : src_oq_q;

    // a live head waits behind a remove event; cancelled heads drain regardless
    assign fifo_wr   = head_live && !src_done;
    assign pop       = head_occ && !(head_live && src_done);
    // any live deferred entry forces later store events behind it to keep order
    assign need_enq  = dst_done && (src_done || pend_cnt != '0);
    assign direct_wr = dst_done && !need_enq;
    assign push      = need_enq && (!fifo_full || pop);
    assign init_wr   = (init_pend_q != '0) && !src_done && !fifo_wr && !direct_wr;

    always_comb begin
        init_oq = '0;
        for (int i = NUM_OUTPUT_QUEUES - 1; i >= 0; i--)
            if (init_pend_q[i]) init_oq = NUM_OQ_WIDTH'(i);
    end

    always_comb begin
        wr_oq       = src_done ? src_oq : fifo_wr ? head[EW-1 -: NUM_OQ_WIDTH] : dst_oq;
        wr_cnt      = src_done ? src_num_pkts_in_q_i :
                      fifo_wr  ? head[PKTS_IN_RAM_WIDTH-1:0] : dst_num_pkts_in_q_i;
        empty_d     = empty_q;
        full_d      = full_q;
        init_pend_d = init_pend_q;
        if (src_done || fifo_wr || direct_wr) begin
            empty_d[wr_oq] = wr_cnt == '0;
            full_d[wr_oq]  = thresh_q[wr_oq] != '0 && wr_cnt >= thresh_q[wr_oq];
        end else if (init_wr) begin
            empty_d[init_oq]     = 1'b1;
            full_d[init_oq]      = 1'b0;
            init_pend_d[init_oq] = 1'b0;
        end
        if (initialize_i) init_pend_d[initialize_oq_i] = 1'b1;
    end

    oq_regs_pend_fifo #(
        .DEPTH (PEND_DEPTH),
        .WIDTH (EW),
        .KEY_W (NUM_OQ_WIDTH),
        .CNT_W (PC_W)
    ) u_pend_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .din_i       ({dst_oq, dst_num_pkts_in_q_i}),
        .kill_i      (initialize_i),
        .kill_key_i  (initialize_oq_i),
        .head_o      (head),
        .head_occ_o  (head_occ),
        .head_live_o (head_live),
        .full_o      (fifo_full),
        .count_o     (pend_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            dst_oq_q        <= '0;
            src_oq_q        <= '0;
            empty_q         <= '1;
            full_q          <= '0;
            init_pend_q     <= '0;
            pend_overflow_q <= 1'b0;
            for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) thresh_q[i] <= '1;
        end else begin
            dst_oq_q    <= dst_oq;
            src_oq_q    <= src_oq;
            empty_q     <= empty_d;
            full_q      <= full_d;
            init_pend_q <= init_pend_d;
            if (need_enq && !push) pend_overflow_q <= 1'b1;
            if (thresh_wr_i) thresh_q[thresh_oq_i] <= thresh_val_i;
        end
    end

    assign empty_o         = empty_q;
    assign full_o          = full_q;
    assign pend_count_o    = pend_cnt;
    assign pend_overflow_o = pend_overflow_q;
endmodule

// File: tb/tb_oq_regs_eval_status.sv
// tb_oq_regs_eval_status: scoreboard bench for oq_regs_eval_status
module tb_oq_regs_eval_status;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dst_update = 1'b0, dst_done = 1'b0, src_update = 1'b0, src_done = 1'b0;
    logic        initialize = 1'b0, thresh_wr = 1'b0;
    logic [2:0]  dst_oq = '0, src_oq = '0, initialize_oq = '0, thresh_oq = '0;
    logic [10:0] dst_cnt = '0, src_cnt = '0, thresh_val = '0;
    logic [7:0]  empty_o, full_o;
    logic [2:0]  pend_count;
    logic        pend_overflow;

    typedef struct {
        string      tag;
        logic [7:0] e;
        logic [7:0] f;
        int         pc;
        logic       ovf;
    } exp_t;
    exp_t sb[$];
    exp_t mx;
    logic [7:0] exp_e = 8'hff, exp_f = 8'h00;
    int   exp_pc = 0;
    logic exp_ovf = 1'b0;
    int   n_checks = 0, n_err = 0;

    oq_regs_eval_status dut (
        .clk                      (clk),
        .reset                    (reset),
        .dst_update_i             (dst_update),
        .dst_oq_i                 (dst_oq),
        .dst_num_pkts_in_q_i      (dst_cnt),
        .dst_num_pkts_in_q_done_i (dst_done),
        .src_update_i             (src_update),
        .src_oq_i                 (src_oq),
        .src_num_pkts_in_q_i      (src_cnt),
        .src_num_pkts_in_q_done_i (src_done),
        .initialize_i             (initialize),
        .initialize_oq_i          (initialize_oq),
        .thresh_wr_i              (thresh_wr),
        .thresh_oq_i              (thresh_oq),
        .thresh_val_i             (thresh_val),
        .empty_o                  (empty_o),
        .full_o                   (full_o),
        .pend_count_o             (pend_count),
        .pend_overflow_o          (pend_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // each expectation is pushed before the edge it describes and popped just after it
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mx = sb.pop_front();
            check({mx.tag, ".empty"}, 32'(empty_o), 32'(mx.e));
            check({mx.tag, ".full"}, 32'(full_o), 32'(mx.f));
            check({mx.tag, ".pend_count"}, 32'(pend_count), 32'(mx.pc));
            check({mx.tag, ".pend_overflow"}, 32'(pend_overflow), 32'(mx.ovf));
        end
    end

    task automatic nxt();
        @(negedge clk);
        reset = 0; dst_update = 0; dst_done = 0; src_update = 0; src_done = 0;
        initialize = 0; thresh_wr = 0;
    endtask

    task automatic expect_now(input string tag);
        exp_t x;
        x.tag = tag; x.e = exp_e; x.f = exp_f; x.pc = exp_pc; x.ovf = exp_ovf;
        sb.push_back(x);
    endtask

    task automatic dst(input int oq, input int cnt, input bit upd);
        dst_update = upd; dst_oq = 3'(oq); dst_done = 1; dst_cnt = 11'(cnt);
    endtask

    task automatic src(input int oq, input int cnt, input bit upd);
        src_update = upd; src_oq = 3'(oq); src_done = 1; src_cnt = 11'(cnt);
    endtask

    task automatic reset_seq(input string tag);
        nxt(); reset = 1;
        nxt(); reset = 1;
        exp_e = 8'hff; exp_f = 8'h00; exp_pc = 0; exp_ovf = 0;
        expect_now(tag);
    endtask

    initial begin
        reset_seq("reset");
        // store update on queue 3
        nxt(); dst(3, 5, 1); exp_e[3] = 0; expect_now("dst_oq3");
        // threshold crossing on queue 2
        nxt(); thresh_wr = 1; thresh_oq = 2; thresh_val = 4; expect_now("thresh_wr");
        nxt(); dst(2, 4, 1); exp_e[2] = 0; exp_f[2] = 1; expect_now("full_at_thresh");
        nxt(); src(2, 3, 1); exp_f[2] = 0; expect_now("below_thresh");
        // threshold 0 means never full; done without update uses latched index 2
        nxt(); thresh_wr = 1; thresh_oq = 2; thresh_val = 0; expect_now("thresh_zero_wr");
        nxt(); dst(0, 0, 0); dst_cnt = 0; exp_e[2] = 1; expect_now("latched_empty");
        nxt(); dst(0, 5, 0); exp_e[2] = 0; expect_now("thresh_zero_never_full");
        // update and done in separate cycles
        nxt(); dst_update = 1; dst_oq = 4; expect_now("update_only");
        nxt(); dst(0, 7, 0); exp_e[4] = 0; expect_now("done_after_update");
        // simultaneous remove and store events
        nxt(); src(1, 2, 1); exp_e[1] = 0; expect_now("src_oq1");
        nxt(); src(1, 0, 1); dst(6, 1, 1); exp_e[1] = 1; exp_pc = 1; expect_now("same_cycle_src");
        nxt(); exp_e[6] = 0; exp_pc = 0; expect_now("deferred_dst");
        // fill and overflow the deferred FIFO
        reset_seq("reset2");
        for (int c = 0; c < 6; c++) begin
            nxt(); src(0, 0, c == 0); dst(2 + c, 1, 1);
            exp_pc = (c + 1 > 4) ? 4 : c + 1; exp_ovf = (c >= 4);
            expect_now($sformatf("fill%0d", c));
        end
        for (int k = 0; k < 5; k++) begin
            nxt();
            if (k < 4) begin exp_e[2 + k] = 0; exp_pc = 3 - k; end
            expect_now($sformatf("drain%0d", k));
        end
        // initialize cancels a queued entry for the same queue
        reset_seq("reset3");
        nxt(); thresh_wr = 1; thresh_oq = 5; thresh_val = 2; expect_now("thresh5");
        nxt(); dst(5, 9, 1); exp_e[5] = 0; exp_f[5] = 1; expect_now("q5_full");
        nxt(); src(0, 0, 1); dst(5, 1, 1); exp_pc = 1; expect_now("q5_queued");
        nxt(); src(0, 0, 0); initialize = 1; initialize_oq = 5; exp_pc = 0; expect_now("q5_cancel");
        nxt(); exp_e[5] = 1; exp_f[5] = 0; expect_now("init5");
        nxt(); expect_now("init5_hold");
        // pending initializes serviced lowest index first
        nxt(); dst(4, 3, 1); exp_e[4] = 0; expect_now("q4_set");
        nxt(); dst(6, 3, 1); exp_e[6] = 0; expect_now("q6_set");
        nxt(); src(0, 0, 1); initialize = 1; initialize_oq = 6; expect_now("init6_req");
        nxt(); src(0, 0, 0); initialize = 1; initialize_oq = 4; expect_now("init4_req");
        nxt(); exp_e[4] = 1; expect_now("init_low_first");
        nxt(); exp_e[6] = 1; expect_now("init_high_next");
        // reset with queued entries and pending initializes
        nxt(); thresh_wr = 1; thresh_oq = 7; thresh_val = 1; expect_now("thresh7");
        nxt(); dst(7, 5, 1); exp_e[7] = 0; exp_f[7] = 1; expect_now("q7_full");
        nxt(); src(0, 0, 1); dst(1, 1, 1); exp_pc = 1; expect_now("q_entry1");
        nxt(); src(0, 0, 0); dst(2, 1, 1); initialize = 1; initialize_oq = 3; exp_pc = 2;
        expect_now("q_entry2");
        nxt(); src(0, 0, 0); dst(4, 1, 1); initialize = 1; initialize_oq = 5; exp_pc = 3;
        expect_now("q_entry3");
        nxt(); reset = 1;
        exp_e = 8'hff; exp_f = 8'h00; exp_pc = 0; exp_ovf = 0; expect_now("mid_reset");
        for (int k = 0; k < 3; k++) begin
            nxt(); expect_now($sformatf("post_reset_quiet%0d", k));
        end
        nxt(); dst(0, 2, 0); exp_e[0] = 0; expect_now("latched_idx_reset");
        nxt(); dst(7, 5, 1); exp_e[7] = 0; expect_now("thresh_reset_ones");
        nxt();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
